// File: rtl/data_cache_ctrl.sv
//------------------------------------------------------------------------------
// data_cache_ctrl : direct-mapped write-through, no-write-allocate data cache.
// Optional hit/miss counters when DCACHE_STATS_EN is defined.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module data_cache_ctrl #(
   parameter int INDEX_BITS = 4,
   parameter int ADDR_BITS  = 32
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 cpu_read,
   input  logic                 cpu_write,
   input  logic                 cpu_sb,
   input  logic [ADDR_BITS-1:0] cpu_addr,
   input  logic [31:0]          cpu_wdata,
   output logic [31:0]          cpu_rdata,
   output logic                 stall,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic                 mem_sb,
   output logic [ADDR_BITS-1:0] mem_addr,
   output logic [31:0]          mem_wdata,
`ifdef DCACHE_STATS_EN
   output logic [31:0]          hit_count,
   output logic [31:0]          miss_count,
`endif
   input  logic [31:0]          mem_rdata,
   input  logic                 mem_ack
);

   localparam int LINES    = 1 << INDEX_BITS;
   localparam int TAG_BITS = ADDR_BITS - INDEX_BITS - 2;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FILL  = 2'd1;
   localparam logic [1:0] WRITE = 2'd2;

   logic [1:0]            state;
   logic [1:0]            state_nxt;
   logic [LINES-1:0]      valid;
   logic [TAG_BITS-1:0]   tag_arr  [LINES];
   logic [31:0]           data_arr [LINES];
   logic                  write_done;

   logic [INDEX_BITS-1:0] index;
   logic [TAG_BITS-1:0]   tag;
   logic                  hit;
   logic                  rd_hit;
   logic                  fill_start;
   logic                  stall_int;

   assign index = cpu_addr[INDEX_BITS+1:2];
   assign tag   = cpu_addr[ADDR_BITS-1:INDEX_BITS+2];
   assign hit   = valid[index] && (tag_arr[index] == tag);

   always_comb begin
      state_nxt  = state;
      stall_int  = 1'b0;
      rd_hit     = 1'b0;
      fill_start = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_sb     = 1'b0;
      mem_addr   = {cpu_addr[ADDR_BITS-1:2], 2'b00};
      mem_wdata  = cpu_wdata;
      case (state)
         IDLE: begin
            // A store wins over a simultaneous load; write_done masks the
            // still-presented store for the single cycle after it completes.
            if (cpu_write) begin
               if (!write_done) begin
                  stall_int = 1'b1;
                  state_nxt = WRITE;
               end
            end else if (cpu_read) begin
               if (hit) begin
                  rd_hit = 1'b1;
               end else begin
                  stall_int  = 1'b1;
                  fill_start = 1'b1;
                  state_nxt  = FILL;
               end
            end
         end
         FILL: begin
            mem_req   = 1'b1;
            stall_int = 1'b1;
            if (mem_ack) state_nxt = IDLE;
         end
         WRITE: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_sb    = cpu_sb;
            mem_addr  = cpu_addr;
            stall_int = 1'b1;
            if (mem_ack) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign stall     = reset & stall_int;
   assign cpu_rdata = (reset && rd_hit) ? data_arr[index] : 32'h0;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         valid      <= '0;
         write_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         write_done <= (state == WRITE) && mem_ack;
         if (state == FILL && mem_ack) valid[index] <= 1'b1;
      end
   end

   // Tag/data storage carries no reset; valid bits alone gate its use.
   always_ff @(posedge clock) begin
      if (state == FILL && mem_ack) begin
         tag_arr[index]  <= tag;
         data_arr[index] <= mem_rdata;
      end else if (state == WRITE && mem_ack && hit) begin
         if (cpu_sb)
            data_arr[index][{cpu_addr[1:0], 3'b000} +: 8] <= cpu_wdata[7:0];
         else
            data_arr[index] <= cpu_wdata;
      end
   end

`ifdef DCACHE_STATS_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         hit_count  <= 32'h0;
         miss_count <= 32'h0;
      end else begin
         if (rd_hit && hit_count != 32'hFFFF_FFFF)
            hit_count <= hit_count + 32'd1;
         if (fill_start && miss_count != 32'hFFFF_FFFF)
            miss_count <= miss_count + 32'd1;
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_data_cache_ctrl.sv
//------------------------------------------------------------------------------
// tb_data_cache_ctrl : scoreboard bench with a latency-programmable memory model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_data_cache_ctrl;

   typedef struct packed {
      logic        we;
      logic        sb;
      logic [31:0] addr;
      logic [31:0] wdata;
   } txn_t;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        cpu_read = 1'b0, cpu_write = 1'b0, cpu_sb = 1'b0;
   logic [31:0] cpu_addr = 32'h0, cpu_wdata = 32'h0;
   logic [31:0] cpu_rdata;
   logic        stall, mem_req, mem_we, mem_sb;
   logic [31:0] mem_addr, mem_wdata;
   logic [31:0] mem_rdata = 32'h0;
   logic        mem_ack = 1'b0;
`ifdef DCACHE_STATS_EN
   logic [31:0] hit_count, miss_count;
`endif

   int checks = 0;
   int failures = 0;
   int lat = 1;
   int cnt = 0;
   logic [31:0] mem [logic [31:0]];
   txn_t        exp_txn [$];
   logic [31:0] exp_rd  [$];

   data_cache_ctrl #(.INDEX_BITS(4), .ADDR_BITS(32)) dut (
      .clock(clock), .reset(reset),
      .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_sb(cpu_sb),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
      .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_sb(mem_sb),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
`ifdef DCACHE_STATS_EN
      .hit_count(hit_count), .miss_count(miss_count),
`endif
      .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Memory model: acks the lat-th cycle of a request and checks the transaction.
   always @(negedge clock) begin
      if (!reset || !mem_req) begin
         cnt = 0;
         mem_ack = 1'b0;
      end else begin
         cnt++;
         if (cnt >= lat) begin
            txn_t e;
            logic [31:0] wa;
            mem_ack = 1'b1;
            cnt = 0;
            wa = {mem_addr[31:2], 2'b00};
            if (exp_txn.size() == 0) begin
               check("unexpected mem txn addr", mem_addr, 32'hFFFF_FFFF);
            end else begin
               e = exp_txn.pop_front();
               check("txn we", {31'h0, mem_we}, {31'h0, e.we});
               check("txn sb", {31'h0, mem_sb}, {31'h0, e.sb});
               check("txn addr", mem_addr, e.addr);
               if (e.we) check("txn wdata", mem_wdata, e.wdata);
            end
            if (!mem.exists(wa)) mem[wa] = 32'h0;
            if (mem_we) begin
               if (mem_sb) mem[wa][{mem_addr[1:0], 3'b000} +: 8] = mem_wdata[7:0];
               else        mem[wa] = mem_wdata;
            end
            mem_rdata = mem[wa];
         end else begin
            mem_ack = 1'b0;
         end
      end
   end

   // Read monitor: every completed load is compared against the scoreboard.
   always @(negedge clock) begin
      if (reset && cpu_read && !cpu_write && !stall) begin
         if (exp_rd.size() == 0) check("unexpected read", cpu_rdata, 32'hFFFF_FFFF);
         else check("read data", cpu_rdata, exp_rd.pop_front());
      end
   end

   function automatic txn_t mk(input logic we, input logic sb, input logic [31:0] a, input logic [31:0] d);
      mk = '{we: we, sb: sb, addr: a, wdata: d};
   endfunction

   task automatic do_op(input string name, input logic rd, input logic wr, input logic sb,
                        input logic [31:0] addr, input logic [31:0] wdata, input int exp_stalls);
      int n = 0;
      cpu_read = rd; cpu_write = wr; cpu_sb = sb; cpu_addr = addr; cpu_wdata = wdata;
      #1;
      while (stall === 1'b1 && n < 50) begin
         @(posedge clock); #1;
         n++;
      end
      check({name, " stall cycles"}, n, exp_stalls);
      @(posedge clock); #1;
      cpu_read = 1'b0; cpu_write = 1'b0; cpu_sb = 1'b0;
   endtask

   initial begin
      mem[32'h40]  = 32'h1234_5678;
      mem[32'h440] = 32'hCAFE_F00D;
      #12;
      check("rst stall", {31'h0, stall}, 32'h0);
      check("rst mem_req", {31'h0, mem_req}, 32'h0);
      check("rst mem_we", {31'h0, mem_we}, 32'h0);
      check("rst mem_sb", {31'h0, mem_sb}, 32'h0);
      check("rst cpu_rdata", cpu_rdata, 32'h0);
      @(posedge clock); #1; reset = 1'b1;
      @(posedge clock); #1;

      lat = 3; exp_txn.push_back(mk(0, 0, 32'h40, 0)); exp_rd.push_back(32'h1234_5678);
      do_op("read 0x40 miss", 1, 0, 0, 32'h40, 0, 4);
      exp_rd.push_back(32'h1234_5678);
      do_op("read 0x40 hit", 1, 0, 0, 32'h40, 0, 0);

      lat = 2; exp_txn.push_back(mk(1, 1, 32'h41, 32'hAB));
      do_op("sb 0x41", 0, 1, 1, 32'h41, 32'hAB, 3);
      exp_rd.push_back(32'h1234_AB78);
      do_op("read after sb", 1, 0, 0, 32'h40, 0, 0);

      lat = 1; exp_txn.push_back(mk(1, 0, 32'h80, 32'h7));
      do_op("write miss 0x80", 0, 1, 0, 32'h80, 32'h7, 2);
      exp_rd.push_back(32'h1234_AB78);
      do_op("0x40 kept after write miss", 1, 0, 0, 32'h40, 0, 0);
      lat = 2; exp_txn.push_back(mk(0, 0, 32'h80, 0)); exp_rd.push_back(32'h7);
      do_op("read 0x80 miss", 1, 0, 0, 32'h80, 0, 3);

      lat = 1; exp_txn.push_back(mk(0, 0, 32'h40, 0)); exp_rd.push_back(32'h1234_AB78);
      do_op("read 0x40 evicted zero-wait", 1, 0, 0, 32'h40, 0, 2);
      lat = 2; exp_txn.push_back(mk(0, 0, 32'h440, 0)); exp_rd.push_back(32'hCAFE_F00D);
      do_op("read 0x440 conflict", 1, 0, 0, 32'h440, 0, 3);
      exp_txn.push_back(mk(0, 0, 32'h40, 0)); exp_rd.push_back(32'h1234_AB78);
      do_op("read 0x40 refetch", 1, 0, 0, 32'h40, 0, 3);

      lat = 1; exp_txn.push_back(mk(1, 0, 32'h40, 32'hDEAD_BEEF));
      do_op("word write hit", 0, 1, 0, 32'h40, 32'hDEAD_BEEF, 2);
      exp_rd.push_back(32'hDEAD_BEEF);
      do_op("read unaligned 0x43 hit", 1, 0, 0, 32'h43, 0, 0);

      exp_txn.push_back(mk(1, 0, 32'h44, 32'h55));
      do_op("read+write treated as write", 1, 1, 0, 32'h44, 32'h55, 2);
      lat = 2; exp_txn.push_back(mk(0, 0, 32'h44, 0)); exp_rd.push_back(32'h55);
      do_op("read 0x46 aligned fill", 1, 0, 0, 32'h46, 0, 3);

      // Abort a fill with reset; the aborted request never acks.
      lat = 20;
      cpu_read = 1'b1; cpu_addr = 32'h84;
      repeat (3) @(posedge clock);
      #1;
      check("fill req before reset", {31'h0, mem_req}, 32'h1);
      reset = 1'b0;
      #1;
      check("abort mem_req", {31'h0, mem_req}, 32'h0);
      check("abort stall", {31'h0, stall}, 32'h0);
`ifdef DCACHE_STATS_EN
      check("rst hit_count", hit_count, 32'h0);
      check("rst miss_count", miss_count, 32'h0);
`endif
      cpu_read = 1'b0;
      @(posedge clock); #1; reset = 1'b1;
      @(posedge clock); #1;
      lat = 2; exp_txn.push_back(mk(0, 0, 32'h40, 0)); exp_rd.push_back(32'hDEAD_BEEF);
      do_op("read 0x40 after reset", 1, 0, 0, 32'h40, 0, 3);
`ifdef DCACHE_STATS_EN
      check("miss_count after reset", miss_count, 32'h1);
`endif

      repeat (3) @(posedge clock);
      check("txn queue drained", exp_txn.size(), 32'h0);
      check("read queue drained", exp_rd.size(), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
